// File: rtl/morse_encoder_if.sv
// Handshake and keying signals between a pattern source and the Morse encoder.
// The source drives start/code/len/abort, and the encoder returns ready/morse_out/done.
interface morse_encoder_if;
    logic       start;
    logic [4:0] code;
    logic [2:0] len;
    logic       abort;
    logic       ready;
    logic       morse_out;
    logic       done;

    modport master (
        output start, code, len, abort,
        input  ready, morse_out, done
    );

    modport slave (
        input  start, code, len, abort,
        output ready, morse_out, done
    );
endinterface

// File: rtl/morse_encoder.sv
// Keys one 5-bit Morse pattern (1=dash, 0=dot, MSB first) onto a timed on/off line.
// Latency: morse_out rises the cycle after an accepted start; done pulses once after the trailing 3-unit gap.
// Backpressure: ready is high only in IDLE; start while busy is dropped, and abort returns to IDLE next cycle.
module morse_encoder #(
    parameter int UNIT_CYCLES = 12500000
) (
    input  logic            clk,
    input  logic            reset,
    morse_encoder_if.slave  bus
);
    localparam int CW = (3 * UNIT_CYCLES > 1) ? $clog2(3 * UNIT_CYCLES) : 1;
    localparam logic [CW-1:0] DOT_LD  = CW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] DASH_LD = CW'(3 * UNIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MARK, GAP, LGAP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4:0]      shift_q, shift_d;
    logic [2:0]      rem_q, rem_d;
    logic            done_q, done_d;
    logic            mo_q, mo_d;
    logic            rdy_q, rdy_d;
    logic            len_ok;

    assign len_ok = (bus.len != 3'd0) && (bus.len <= 3'd5);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            mo_q    <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            mo_q    <= mo_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        rem_d   = rem_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && len_ok) begin
                    shift_d = bus.code;
                    rem_d   = bus.len - 3'd1;
                    cnt_d   = bus.code[4] ? DASH_LD : DOT_LD;
                    state_d = MARK;
                end
            end
            MARK: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    if (rem_q != 3'd0) begin
                        shift_d = {shift_q[3:0], 1'b0};
                        rem_d   = rem_q - 3'd1;
                        cnt_d   = DOT_LD;
                        state_d = GAP;
                    end else begin
                        cnt_d   = DASH_LD;
                        state_d = LGAP;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GAP: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    // shift_q already holds the next symbol in its MSB
                    cnt_d   = shift_q[4] ? DASH_LD : DOT_LD;
                    state_d = MARK;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            LGAP: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        mo_d  = (state_d == MARK);
        rdy_d = (state_d == IDLE);
    end

    assign bus.morse_out = mo_q;
    assign bus.ready     = rdy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench for morse_encoder with UNIT_CYCLES=4 (dot 4, dash 12, letter gap 12 cycles).
// Traces hold cycle 1 after the accept edge in the highest used bit.
module tb_morse_encoder;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    morse_encoder_if bus ();

    morse_encoder #(.UNIT_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Caller raises start just before; this consumes the accept edge and samples n cycles.
    task automatic trace(input int n, input int poke_at, input logic [4:0] pcode,
                         input logic [2:0] plen, output logic [63:0] mo,
                         output logic [63:0] dn, output logic [63:0] rd);
        mo = '0; dn = '0; rd = '0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int c = 1; c <= n; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            mo[n-c] = bus.morse_out;
            dn[n-c] = bus.done;
            rd[n-c] = bus.ready;
            if (c == poke_at) begin
                bus.start = 1'b1;
                bus.code  = pcode;
                bus.len   = plen;
            end else begin
                bus.start = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            bus.start = 1'($urandom);
            bus.code  = 5'($urandom);
            bus.len   = 3'($urandom);
            bus.abort = 1'($urandom);
            tests++;
            if ({bus.ready, bus.morse_out, bus.done} !== 3'b100) begin
                fails++;
                $display("FAIL reset_hold cyc%0d got rdy/mo/done=%b want 100", i,
                         {bus.ready, bus.morse_out, bus.done});
            end
        end
        bus.start = 1'b0; bus.abort = 1'b0; bus.code = '0; bus.len = '0;
        reset = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({bus.ready, bus.morse_out, bus.done} !== 3'b100) begin
            fails++;
            $display("FAIL reset_release got rdy/mo/done=%b want 100",
                     {bus.ready, bus.morse_out, bus.done});
        end
    endtask

    task automatic test_letter_a();
        logic [63:0] mo, dn, rd;
        bus.code = 5'b01000; bus.len = 3'd2; bus.start = 1'b1;
        trace(33, 0, 5'b0, 3'd0, mo, dn, rd);
        tests++;
        if (mo !== 64'h0_0000_0000_F0FF_F000 << 1) begin
            fails++; $display("FAIL a_morse_out got %h want %h", mo, 64'h1_E1FF_E000);
        end
        tests++;
        if (dn !== 64'h1) begin
            fails++; $display("FAIL a_done got %h want %h", dn, 64'h1);
        end
        tests++;
        if (rd !== 64'h1) begin
            fails++; $display("FAIL a_ready got %h want %h", rd, 64'h1);
        end
    endtask

    task automatic test_letter_5_ignore_start();
        logic [63:0] mo, dn, rd;
        bus.code = 5'b00000; bus.len = 3'd5; bus.start = 1'b1;
        trace(49, 10, 5'b11111, 3'd5, mo, dn, rd);
        tests++;
        if (mo !== {15'h0, 48'hF0F0_F0F0_F000, 1'b0}) begin
            fails++; $display("FAIL five_morse_out got %h want %h", mo,
                              {15'h0, 48'hF0F0_F0F0_F000, 1'b0});
        end
        tests++;
        if (dn !== 64'h1) begin
            fails++; $display("FAIL five_done got %h want %h", dn, 64'h1);
        end
        tests++;
        if (rd !== 64'h1) begin
            fails++; $display("FAIL five_ready got %h want %h", rd, 64'h1);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] mo, dn, rd;
        bus.code = 5'b01000; bus.len = 3'd2; bus.start = 1'b1;
        trace(58, 33, 5'b10000, 3'd1, mo, dn, rd);
        tests++;
        if (mo !== {6'h0, 32'hF0FF_F000, 1'b0, 12'hFFF, 12'h000, 1'b0}) begin
            fails++; $display("FAIL b2b_morse_out got %h want %h", mo,
                              {6'h0, 32'hF0FF_F000, 1'b0, 12'hFFF, 12'h000, 1'b0});
        end
        tests++;
        if (dn !== {6'h0, 32'h0, 1'b1, 24'h0, 1'b1}) begin
            fails++; $display("FAIL b2b_done got %h want %h", dn,
                              {6'h0, 32'h0, 1'b1, 24'h0, 1'b1});
        end
        tests++;
        if (rd !== {6'h0, 32'h0, 1'b1, 24'h0, 1'b1}) begin
            fails++; $display("FAIL b2b_ready got %h want %h", rd,
                              {6'h0, 32'h0, 1'b1, 24'h0, 1'b1});
        end
    endtask

    task automatic test_invalid();
        logic [2:0] bad_len [2];
        bad_len[0] = 3'd0;
        bad_len[1] = 3'd6;
        for (int k = 0; k < 2; k++) begin
            bus.code = 5'b11111; bus.len = bad_len[k]; bus.start = 1'b1;
            for (int i = 0; i < 6; i++) begin
                @(posedge clk); #1;
                tests++;
                if ({bus.ready, bus.morse_out, bus.done} !== 3'b100) begin
                    fails++;
                    $display("FAIL invalid_len%0d cyc%0d got rdy/mo/done=%b want 100",
                             bad_len[k], i, {bus.ready, bus.morse_out, bus.done});
                end
            end
            bus.start = 1'b0;
        end
    endtask

    task automatic test_abort();
        logic [63:0] mo, dn, rd;
        bus.code = 5'b10000; bus.len = 3'd1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++;
        if (bus.morse_out !== 1'b1) begin
            fails++; $display("FAIL abort_dash_cyc3 got mo=%b want 1", bus.morse_out);
        end
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        tests++;
        if ({bus.ready, bus.morse_out, bus.done} !== 3'b100) begin
            fails++; $display("FAIL abort_next got rdy/mo/done=%b want 100",
                              {bus.ready, bus.morse_out, bus.done});
        end
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            tests++;
            if ({bus.ready, bus.morse_out, bus.done} !== 3'b100) begin
                fails++; $display("FAIL abort_idle cyc%0d got rdy/mo/done=%b want 100",
                                  i, {bus.ready, bus.morse_out, bus.done});
            end
        end
        // abort together with start in IDLE: the start wins
        bus.code = 5'b00000; bus.len = 3'd1; bus.start = 1'b1; bus.abort = 1'b1;
        trace(17, 0, 5'b0, 3'd0, mo, dn, rd);
        tests++;
        if (mo !== 64'h1E000) begin
            fails++; $display("FAIL abort_then_e_morse_out got %h want %h", mo, 64'h1E000);
        end
        tests++;
        if (dn !== 64'h1) begin
            fails++; $display("FAIL abort_then_e_done got %h want %h", dn, 64'h1);
        end
    endtask

    task automatic test_reset_mid_gap();
        logic [63:0] mo, dn, rd;
        bus.code = 5'b01000; bus.len = 3'd2; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 2; c <= 6; c++) begin @(posedge clk); #1; end
        tests++;
        if ({bus.ready, bus.morse_out} !== 2'b00) begin
            fails++; $display("FAIL rst_gap_pre got rdy/mo=%b want 00",
                              {bus.ready, bus.morse_out});
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if ({bus.ready, bus.morse_out, bus.done} !== 3'b100) begin
            fails++; $display("FAIL rst_gap_async got rdy/mo/done=%b want 100",
                              {bus.ready, bus.morse_out, bus.done});
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({bus.ready, bus.morse_out, bus.done} !== 3'b100) begin
            fails++; $display("FAIL rst_gap_release got rdy/mo/done=%b want 100",
                              {bus.ready, bus.morse_out, bus.done});
        end
        bus.code = 5'b00000; bus.len = 3'd1; bus.start = 1'b1;
        trace(17, 0, 5'b0, 3'd0, mo, dn, rd);
        tests++;
        if (mo !== 64'h1E000) begin
            fails++; $display("FAIL rst_then_e_morse_out got %h want %h", mo, 64'h1E000);
        end
        tests++;
        if (dn !== 64'h1) begin
            fails++; $display("FAIL rst_then_e_done got %h want %h", dn, 64'h1);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        bus.start = 1'b0; bus.code = '0; bus.len = '0; bus.abort = 1'b0;
        test_reset();
        test_letter_a();
        test_letter_5_ignore_start();
        test_back_to_back();
        test_invalid();
        test_abort();
        test_reset_mid_gap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
